// File: rtl/tracker_pkg.sv
// Shared tracker types: angle/intensity words, sweep state encoding and default geometry.
package tracker_pkg;

   localparam int unsigned ANGLE_W_DEF   = 8;
   localparam int unsigned LDR_W_DEF     = 10;
   localparam int unsigned MAX_ANGLE_DEF = 180;

   typedef logic [ANGLE_W_DEF-1:0] angle_t;
   typedef logic [LDR_W_DEF-1:0]   ldr_t;

   typedef enum logic [2:0] {
      IDLE,
      BASE_SWEEP,
      PARK,
      ARM_SWEEP,
      DONE
   } state_t;

endpackage

// File: rtl/axis_sweeper.sv
// One-axis sweep engine: angle stepping, per-position settle countdown and running best sample.
module axis_sweeper #(
   parameter int unsigned ANGLE_W   = 8,
   parameter int unsigned LDR_W     = 10,
   parameter int unsigned MAX_ANGLE = 180,
   parameter int unsigned STEP      = 1,
   parameter int unsigned SETTLE_W  = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic [SETTLE_W-1:0] settle,
   input  logic                restart,
   input  logic                en,
   input  logic [LDR_W-1:0]    ldr,
   output logic [ANGLE_W-1:0]  angle_d_c,
   output logic [ANGLE_W-1:0]  best_angle_c,
   output logic [LDR_W-1:0]    best_val_c,
   output logic                last_c
);

   localparam int unsigned SUM_W = ANGLE_W + 1;

   logic [SETTLE_W-1:0] s_q;
   logic [SETTLE_W-1:0] cnt;
   logic [ANGLE_W-1:0]  angle;
   logic [ANGLE_W-1:0]  best_angle;
   logic [LDR_W-1:0]    best_val;
   logic                seen;
   logic                tick_c;
   logic                accept_c;
   logic                over_c;
   logic [SUM_W-1:0]    next_sum_c;

   // Outputs depend only on local state and ldr, so the caller can gate them without a comb loop.
   always_comb begin
      tick_c       = (cnt == SETTLE_W'(1));
      accept_c     = tick_c && (!seen || (ldr > best_val));
      best_angle_c = accept_c ? angle : best_angle;
      best_val_c   = accept_c ? ldr : best_val;
      next_sum_c   = {1'b0, angle} + SUM_W'(STEP);
      over_c       = (next_sum_c > SUM_W'(MAX_ANGLE));
      last_c       = tick_c && over_c;
      angle_d_c    = (tick_c && !over_c) ? next_sum_c[ANGLE_W-1:0] : angle;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s_q        <= '0;
         cnt        <= '0;
         angle      <= '0;
         best_angle <= '0;
         best_val   <= '0;
         seen       <= 1'b0;
      end else begin
         if (load) begin
            s_q <= (settle == '0) ? SETTLE_W'(1) : settle;
         end
         if (restart) begin
            angle      <= '0;
            cnt        <= s_q;
            best_angle <= '0;
            best_val   <= '0;
            seen       <= 1'b0;
         end else if (en) begin
            angle      <= angle_d_c;
            best_angle <= best_angle_c;
            best_val   <= best_val_c;
            if (tick_c) begin
               seen <= 1'b1;
               if (!over_c) begin
                  cnt <= s_q;
               end
            end else begin
               cnt <= cnt - SETTLE_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/sweep_peak_finder.sv
// Two-axis peak search: sweep base, park at brightest, sweep arm; optional arm-only refine.
module sweep_peak_finder
   import tracker_pkg::*;
#(
   parameter int unsigned ANGLE_W   = ANGLE_W_DEF,
   parameter int unsigned LDR_W     = LDR_W_DEF,
   parameter int unsigned MAX_ANGLE = MAX_ANGLE_DEF,
   parameter int unsigned STEP      = 1,
   parameter int unsigned SETTLE_W  = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                abort,
   input  logic                mode,
   input  logic [SETTLE_W-1:0] settle,
   input  logic [LDR_W-1:0]    ldr,
   output logic [ANGLE_W-1:0]  base,
   output logic [ANGLE_W-1:0]  arm,
   output logic [LDR_W-1:0]    peak,
   output logic                busy,
   output logic                done
);

   state_t              state, state_n;
   logic                start_q;
   logic                mode_q;
   logic [ANGLE_W-1:0]  base_n, arm_n;
   logic [LDR_W-1:0]    peak_n;
   logic                busy_n, done_n;
   logic                load_c, restart_c, en_c;
   logic [ANGLE_W-1:0]  angle_d_c;
   logic [ANGLE_W-1:0]  best_angle_c;
   logic [LDR_W-1:0]    best_val_c;
   logic                last_c;

   axis_sweeper #(
      .ANGLE_W   (ANGLE_W),
      .LDR_W     (LDR_W),
      .MAX_ANGLE (MAX_ANGLE),
      .STEP      (STEP),
      .SETTLE_W  (SETTLE_W)
   ) u_axis (
      .clk          (clk),
      .rst          (rst),
      .load         (load_c),
      .settle       (settle),
      .restart      (restart_c),
      .en           (en_c),
      .ldr          (ldr),
      .angle_d_c    (angle_d_c),
      .best_angle_c (best_angle_c),
      .best_val_c   (best_val_c),
      .last_c       (last_c)
   );

   // Start is captured (with settle and mode) one cycle before the first sweep cycle.
   always_comb begin
      state_n   = state;
      base_n    = base;
      arm_n     = arm;
      peak_n    = peak;
      busy_n    = busy;
      done_n    = 1'b0;
      load_c    = 1'b0;
      restart_c = 1'b0;
      en_c      = 1'b0;
      unique case (state)
         IDLE: begin
            if (start_q) begin
               restart_c = 1'b1;
               busy_n    = 1'b1;
               arm_n     = '0;
               if (mode_q) begin
                  state_n = PARK;
               end else begin
                  state_n = BASE_SWEEP;
                  base_n  = '0;
               end
            end else if (start) begin
               load_c = 1'b1;
            end
         end
         BASE_SWEEP: begin
            if (abort) begin
               state_n = IDLE;
               busy_n  = 1'b0;
            end else begin
               en_c   = 1'b1;
               base_n = angle_d_c;
               if (last_c) begin
                  state_n = PARK;
                  base_n  = best_angle_c;
                  peak_n  = best_val_c;
                  arm_n   = '0;
               end
            end
         end
         PARK: begin
            if (abort) begin
               state_n = IDLE;
               busy_n  = 1'b0;
            end else begin
               restart_c = 1'b1;
               arm_n     = '0;
               state_n   = ARM_SWEEP;
            end
         end
         ARM_SWEEP: begin
            if (abort) begin
               state_n = IDLE;
               busy_n  = 1'b0;
            end else begin
               en_c  = 1'b1;
               arm_n = angle_d_c;
               if (last_c) begin
                  state_n = DONE;
                  arm_n   = best_angle_c;
                  peak_n  = best_val_c;
                  done_n  = 1'b1;
                  busy_n  = 1'b0;
               end
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         start_q <= 1'b0;
         mode_q  <= 1'b0;
         base    <= '0;
         arm     <= '0;
         peak    <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_n;
         start_q <= load_c;
         if (load_c) begin
            mode_q <= mode;
         end
         base <= base_n;
         arm  <= arm_n;
         peak <= peak_n;
         busy <= busy_n;
         done <= done_n;
      end
   end

endmodule

// File: tb/tb_sweep_peak_finder.sv
// Self-checking bench: random light landscapes against a brute-force argmax model of the sweep.
module tb_sweep_peak_finder;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_a, abort_a, mode_a;
   logic [31:0] settle_a;
   logic [9:0]  ldr_a;
   logic [7:0]  base_a, arm_a;
   logic [9:0]  peak_a;
   logic        busy_a, done_a;
   logic        start_b, abort_b, mode_b;
   logic [31:0] settle_b;
   logic [9:0]  ldr_b;
   logic [7:0]  base_b, arm_b;
   logic [9:0]  peak_b;
   logic        busy_b, done_b;

   bit pat_flat;
   int flat_val, pk_b, pk_a;
   int checks = 0;
   int failures = 0;
   int done_cnt_a = 0;
   int over_cnt = 0;
   int exp_base_a = 0;

   always #5 clk = ~clk;

   function automatic int intensity(int b, int a, bit fl, int fv, int pb, int pa);
      int db, da;
      if (fl) return fv;
      db = (b > pb) ? b - pb : pb - b;
      da = (a > pa) ? a - pa : pa - a;
      return 1000 - db - da;
   endfunction

   assign ldr_a = 10'(intensity(int'(base_a), int'(arm_a), pat_flat, flat_val, pk_b, pk_a));
   assign ldr_b = 10'(intensity(int'(base_b), int'(arm_b), pat_flat, flat_val, pk_b, pk_a));

   sweep_peak_finder #(.ANGLE_W(8), .LDR_W(10), .MAX_ANGLE(180), .STEP(1), .SETTLE_W(32)) dut (
      .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .mode(mode_a), .settle(settle_a),
      .ldr(ldr_a), .base(base_a), .arm(arm_a), .peak(peak_a), .busy(busy_a), .done(done_a));

   sweep_peak_finder #(.ANGLE_W(8), .LDR_W(10), .MAX_ANGLE(180), .STEP(7), .SETTLE_W(32)) dut7 (
      .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .mode(mode_b), .settle(settle_b),
      .ldr(ldr_b), .base(base_b), .arm(arm_b), .peak(peak_b), .busy(busy_b), .done(done_b));

   always @(posedge clk) if (done_a === 1'b1) done_cnt_a++;

   always @(negedge clk)
      if (rst === 1'b0 && (base_a > 8'd180 || arm_a > 8'd180 || base_b > 8'd180 || arm_b > 8'd180))
         over_cnt++;

   // Brute force over every legal angle: brightest wins, first (lowest) angle wins ties.
   task automatic model(input int step, input bit m, input int cur_base, output int eb, output int ea, output int ep);
      int bv;
      eb = cur_base;
      if (!m) begin
         bv = -1;
         for (int x = 0; x <= 180; x += step) begin
            if (intensity(x, 0, pat_flat, flat_val, pk_b, pk_a) > bv) begin
               bv = intensity(x, 0, pat_flat, flat_val, pk_b, pk_a);
               eb = x;
            end
         end
      end
      bv = -1;
      ea = 0;
      for (int x = 0; x <= 180; x += step) begin
         if (intensity(eb, x, pat_flat, flat_val, pk_b, pk_a) > bv) begin
            bv = intensity(eb, x, pat_flat, flat_val, pk_b, pk_a);
            ea = x;
         end
      end
      ep = bv;
   endtask

   function automatic int exp_done(int step, bit m, int st);
      int n, s;
      n = 180 / step + 1;
      s = (st == 0) ? 1 : st;
      return m ? n * s + 2 : 2 * n * s + 2;
   endfunction

   // Cycle k is the period after the k-th rising edge following the edge that samples start.
   task automatic run_search(input bit sel7, input bit m, input int st, input bit spurious,
                             output int done_cyc, output logic busy1, output logic done_after);
      if (sel7) begin start_b = 1'b1; mode_b = m; settle_b = st; end
      else      begin start_a = 1'b1; mode_a = m; settle_a = st; end
      @(posedge clk); #1;
      start_a = 1'b0; start_b = 1'b0;
      settle_a = $urandom; settle_b = $urandom;
      mode_a = 1'($urandom); mode_b = 1'($urandom);
      done_cyc = -1;
      busy1 = 1'b0;
      for (int k = 1; k <= 1500; k++) begin
         @(posedge clk); #1;
         if (k == 1) busy1 = sel7 ? busy_b : busy_a;
         start_a = spurious && (k > 2) && (k < 150) && (k % 23 == 0);
         if ((sel7 ? done_b : done_a) === 1'b1) begin
            done_cyc = k;
            break;
         end
      end
      start_a = 1'b0;
      @(posedge clk); #1;
      done_after = sel7 ? done_b : done_a;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (base_a !== 8'd0) begin failures++; $display("FAIL reset_base got=%0d exp=0", base_a); end
      checks++; if (arm_a !== 8'd0) begin failures++; $display("FAIL reset_arm got=%0d exp=0", arm_a); end
      checks++; if (peak_a !== 10'd0) begin failures++; $display("FAIL reset_peak got=%0d exp=0", peak_a); end
      checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_a); end
      checks++; if (done_a !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done_a); end
      checks++; if (base_b !== 8'd0 || busy_b !== 1'b0) begin failures++; $display("FAIL reset_dut7 base=%0d busy=%b exp=0/0", base_b, busy_b); end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_peak();
      int eb, ea, ep, dc;
      logic b1, da;
      pat_flat = 1'b0; pk_b = 37; pk_a = 112;
      model(1, 1'b0, exp_base_a, eb, ea, ep);
      run_search(1'b0, 1'b0, 2, 1'b0, dc, b1, da);
      exp_base_a = eb;
      checks++; if (base_a !== 8'(eb)) begin failures++; $display("FAIL peak_base got=%0d exp=%0d", base_a, eb); end
      checks++; if (arm_a !== 8'(ea)) begin failures++; $display("FAIL peak_arm got=%0d exp=%0d", arm_a, ea); end
      checks++; if (peak_a !== 10'(ep)) begin failures++; $display("FAIL peak_peak got=%0d exp=%0d", peak_a, ep); end
      checks++; if (dc != exp_done(1, 1'b0, 2)) begin failures++; $display("FAIL peak_done_cycle got=%0d exp=%0d", dc, exp_done(1, 1'b0, 2)); end
      checks++; if (b1 !== 1'b1) begin failures++; $display("FAIL peak_busy_cycle1 got=%b exp=1", b1); end
      checks++; if (da !== 1'b0 || busy_a !== 1'b0) begin failures++; $display("FAIL peak_after_done done=%b busy=%b exp=0/0", da, busy_a); end
   endtask

   task automatic test_refine();
      int eb, ea, ep, dc;
      logic b1, da;
      pat_flat = 1'b0; pk_b = 37; pk_a = 112;
      model(1, 1'b1, exp_base_a, eb, ea, ep);
      run_search(1'b0, 1'b1, 0, 1'b0, dc, b1, da);
      checks++; if (base_a !== 8'(eb)) begin failures++; $display("FAIL refine_base got=%0d exp=%0d", base_a, eb); end
      checks++; if (arm_a !== 8'(ea)) begin failures++; $display("FAIL refine_arm got=%0d exp=%0d", arm_a, ea); end
      checks++; if (peak_a !== 10'(ep)) begin failures++; $display("FAIL refine_peak got=%0d exp=%0d", peak_a, ep); end
      checks++; if (dc != exp_done(1, 1'b1, 0)) begin failures++; $display("FAIL refine_done_cycle got=%0d exp=%0d", dc, exp_done(1, 1'b1, 0)); end
   endtask

   task automatic test_flat();
      int eb, ea, ep, dc;
      logic b1, da;
      int vals [2] = '{500, 0};
      for (int i = 0; i < 2; i++) begin
         pat_flat = 1'b1; flat_val = vals[i];
         model(1, 1'b0, exp_base_a, eb, ea, ep);
         run_search(1'b0, 1'b0, 1, 1'b0, dc, b1, da);
         exp_base_a = eb;
         checks++; if (base_a !== 8'(eb) || arm_a !== 8'(ea)) begin failures++; $display("FAIL flat_angles got=%0d/%0d exp=%0d/%0d", base_a, arm_a, eb, ea); end
         checks++; if (peak_a !== 10'(ep)) begin failures++; $display("FAIL flat_peak got=%0d exp=%0d", peak_a, ep); end
      end
   endtask

   task automatic test_step7();
      int eb, ea, ep, dc;
      logic b1, da;
      pat_flat = 1'b0; pk_b = 179; pk_a = $urandom_range(0, 180);
      model(7, 1'b0, 0, eb, ea, ep);
      run_search(1'b1, 1'b0, 2, 1'b0, dc, b1, da);
      checks++; if (base_b !== 8'(eb)) begin failures++; $display("FAIL step7_base got=%0d exp=%0d", base_b, eb); end
      checks++; if (arm_b !== 8'(ea)) begin failures++; $display("FAIL step7_arm got=%0d exp=%0d", arm_b, ea); end
      checks++; if (peak_b !== 10'(ep)) begin failures++; $display("FAIL step7_peak got=%0d exp=%0d", peak_b, ep); end
      checks++; if (dc != exp_done(7, 1'b0, 2)) begin failures++; $display("FAIL step7_done_cycle got=%0d exp=%0d", dc, exp_done(7, 1'b0, 2)); end
   endtask

   task automatic test_abort();
      int eb, ea, ep, dc, snap;
      logic b1, da;
      pat_flat = 1'b0; pk_b = $urandom_range(60, 180); pk_a = $urandom_range(0, 180);
      snap = done_cnt_a;
      start_a = 1'b1; mode_a = 1'b0; settle_a = 2;
      @(posedge clk); #1;
      start_a = 1'b0;
      for (int k = 1; k < 100; k++) begin
         @(posedge clk); #1;
         if (k == 99) abort_a = 1'b1;
      end
      @(posedge clk); #1;
      abort_a = 1'b0;
      checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy_a); end
      checks++; if (base_a !== 8'd49 || arm_a !== 8'd0) begin failures++; $display("FAIL abort_frozen got=%0d/%0d exp=49/0", base_a, arm_a); end
      checks++; if (done_a !== 1'b0 || done_cnt_a != snap) begin failures++; $display("FAIL abort_no_done done=%b count=%0d exp=0/%0d", done_a, done_cnt_a, snap); end
      model(1, 1'b0, 49, eb, ea, ep);
      run_search(1'b0, 1'b0, 2, 1'b0, dc, b1, da);
      exp_base_a = eb;
      checks++; if (base_a !== 8'(eb) || arm_a !== 8'(ea) || peak_a !== 10'(ep)) begin failures++; $display("FAIL abort_restart got=%0d/%0d/%0d exp=%0d/%0d/%0d", base_a, arm_a, peak_a, eb, ea, ep); end
      checks++; if (dc != exp_done(1, 1'b0, 2)) begin failures++; $display("FAIL abort_restart_cycle got=%0d exp=%0d", dc, exp_done(1, 1'b0, 2)); end
   endtask

   task automatic test_reset_mid();
      start_a = 1'b1; mode_a = 1'b0; settle_a = 2;
      @(posedge clk); #1;
      start_a = 1'b0;
      for (int k = 1; k < 50; k++) begin
         @(posedge clk); #1;
         if (k == 49) rst = 1'b1;
      end
      @(posedge clk); #1;
      rst = 1'b0;
      checks++; if (base_a !== 8'd0 || arm_a !== 8'd0 || peak_a !== 10'd0) begin failures++; $display("FAIL rst_mid_outputs got=%0d/%0d/%0d exp=0/0/0", base_a, arm_a, peak_a); end
      checks++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin failures++; $display("FAIL rst_mid_flags busy=%b done=%b exp=0/0", busy_a, done_a); end
      exp_base_a = 0;
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      int eb, ea, ep, dc, snap;
      logic b1, da;
      for (int i = 0; i < 2; i++) begin
         pat_flat = 1'b0; pk_b = $urandom_range(0, 180); pk_a = $urandom_range(0, 180);
         snap = done_cnt_a;
         model(1, 1'b0, exp_base_a, eb, ea, ep);
         run_search(1'b0, 1'b0, 1, 1'b1, dc, b1, da);
         exp_base_a = eb;
         checks++; if (done_cnt_a - snap != 1) begin failures++; $display("FAIL b2b_done_count got=%0d exp=1", done_cnt_a - snap); end
         checks++; if (base_a !== 8'(eb) || arm_a !== 8'(ea) || peak_a !== 10'(ep)) begin failures++; $display("FAIL b2b_result got=%0d/%0d/%0d exp=%0d/%0d/%0d", base_a, arm_a, peak_a, eb, ea, ep); end
         checks++; if (dc != exp_done(1, 1'b0, 1)) begin failures++; $display("FAIL b2b_done_cycle got=%0d exp=%0d", dc, exp_done(1, 1'b0, 1)); end
      end
   endtask

   task automatic test_random();
      int eb, ea, ep, dc, st;
      logic b1, da;
      bit m;
      for (int i = 0; i < 4; i++) begin
         pat_flat = 1'b0; pk_b = $urandom_range(0, 180); pk_a = $urandom_range(0, 180);
         st = $urandom_range(0, 3);
         m = 1'($urandom);
         model(1, m, exp_base_a, eb, ea, ep);
         run_search(1'b0, m, st, 1'b0, dc, b1, da);
         exp_base_a = eb;
         checks++; if (base_a !== 8'(eb) || arm_a !== 8'(ea) || peak_a !== 10'(ep)) begin failures++; $display("FAIL rand_result mode=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", m, base_a, arm_a, peak_a, eb, ea, ep); end
         checks++; if (dc != exp_done(1, m, st)) begin failures++; $display("FAIL rand_done_cycle mode=%0d settle=%0d got=%0d exp=%0d", m, st, dc, exp_done(1, m, st)); end
      end
   endtask

   task automatic test_angle_bound();
      checks++; if (over_cnt != 0) begin failures++; $display("FAIL angle_bound got=%0d cycles above 180 exp=0", over_cnt); end
   endtask

   initial begin
      rst = 1'b1;
      start_a = 1'b0; abort_a = 1'b0; mode_a = 1'b0; settle_a = 0;
      start_b = 1'b0; abort_b = 1'b0; mode_b = 1'b0; settle_b = 0;
      pat_flat = 1'b0; flat_val = 0; pk_b = 0; pk_a = 0;
      test_reset();
      test_peak();
      test_refine();
      test_flat();
      test_step7();
      test_abort();
      test_reset_mid();
      test_back_to_back();
      test_random();
      test_angle_bound();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
